// File: rtl/rojo_pkg.sv
// Shared register map, STATUS field positions and the snapshot layout for the Rojobot capture block.
package rojo_pkg;

    localparam logic [1:0] RJ_SNAP   = 2'd0;
    localparam logic [1:0] RJ_STATUS = 2'd1;
    localparam logic [1:0] RJ_MOTCTL = 2'd2;
    localparam logic [1:0] RJ_IRQEN  = 2'd3;

    // STATUS read fields and write-one command bits
    localparam int STAT_PEND_BIT    = 0;
    localparam int STAT_OVR_CLR_BIT = 1;
    localparam int STAT_CNT_LSB     = 8;
    localparam int STAT_CNT_MSB     = 23;
    localparam int STAT_OVR_LSB     = 24;
    localparam int STAT_OVR_MSB     = 31;

    typedef struct packed {
        logic [7:0] locx;
        logic [7:0] locy;
        logic [7:0] sensors;
        logic [7:0] botinfo;
    } rojo_snap_t;

endpackage

// File: rtl/rojo_edge_det.sv
// Rising-edge detector on a level input; pulse is combinational off a registered copy, 0 latency.
// A level already high on the first clock after reset is swallowed, never reported as an edge.
module rojo_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_lvl,
    output logic o_rise
);

    logic lvl_d_q;
    logic armed_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lvl_d_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            lvl_d_q <= i_lvl;
            armed_q <= 1'b1;
        end
    end

    assign o_rise = i_lvl & ~lvl_d_q & armed_q;

endmodule

// File: rtl/rojo_update_capture.sv
// Snapshots Rojobot status on each update strobe and exposes it on Wishbone with pending/irq/counters.
// Bus accesses ack one cycle after strobe, never stall beyond that; the capture side has no backpressure.
module rojo_update_capture
    import rojo_pkg::*;
#(
    parameter int UPD_CNT_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_upd_sysregs,
    input  logic [7:0]  i_locx,
    input  logic [7:0]  i_locy,
    input  logic [7:0]  i_sensors,
    input  logic [7:0]  i_botinfo,
    output logic [7:0]  o_motctl,
    input  logic [3:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_rdt,
    output logic        o_irq
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    logic                 upd_rise;
    logic [0:0]           bus_st_q,   bus_st_d;
    rojo_snap_t           snap_q,     snap_d;
    logic                 pending_q,  pending_d;
    logic [UPD_CNT_W-1:0] upd_cnt_q,  upd_cnt_d;
    logic [7:0]           overrun_q,  overrun_d;
    logic                 irq_en_q,   irq_en_d;
    logic [7:0]           motctl_q,   motctl_d;
    logic [31:0]          rdt_q,      rdt_d;
    logic                 irq_q,      irq_d;

    logic        access, wr, status_wr, ack_clr, ovr_clr;
    logic [1:0]  reg_idx;
    logic [15:0] cnt_ext;
    logic [31:0] status_word, rd_word;
    logic        unused_bus_bits;

    rojo_edge_det u_upd_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_lvl  (i_upd_sysregs),
        .o_rise (upd_rise)
    );

    assign unused_bus_bits = ^{i_wb_adr[1:0], i_wb_sel[3:1], i_wb_dat[31:8]};

    always_comb begin
        reg_idx   = i_wb_adr[3:2];
        access    = i_wb_cyc & i_wb_stb & (bus_st_q == ST_IDLE);
        wr        = access & i_wb_we;
        status_wr = wr & (reg_idx == RJ_STATUS) & i_wb_sel[0];
        ack_clr   = status_wr & i_wb_dat[STAT_PEND_BIT];
        ovr_clr   = status_wr & i_wb_dat[STAT_OVR_CLR_BIT];

        cnt_ext = '0;
        cnt_ext[UPD_CNT_W-1:0] = upd_cnt_q;
        status_word = '0;
        status_word[STAT_OVR_MSB:STAT_OVR_LSB] = overrun_q;
        status_word[STAT_CNT_MSB:STAT_CNT_LSB] = cnt_ext;
        status_word[STAT_PEND_BIT]             = pending_q;

        unique case (reg_idx)
            RJ_SNAP:   rd_word = snap_q;
            RJ_STATUS: rd_word = status_word;
            RJ_MOTCTL: rd_word = {24'd0, motctl_q};
            default:   rd_word = {31'd0, irq_en_q};
        endcase
    end

    always_comb begin
        snap_d    = snap_q;
        pending_d = pending_q;
        upd_cnt_d = upd_cnt_q;
        overrun_d = overrun_q;
        irq_en_d  = irq_en_q;
        motctl_d  = motctl_q;

        // An update landing on the same edge as an ack wins and is not counted as an overrun.
        if (upd_rise) begin
            snap_d    = '{locx: i_locx, locy: i_locy, sensors: i_sensors, botinfo: i_botinfo};
            pending_d = 1'b1;
            upd_cnt_d = upd_cnt_q + 1'b1;
            if (pending_q && !ack_clr && overrun_q != 8'hFF) begin
                overrun_d = overrun_q + 8'd1;
            end
        end else if (ack_clr) begin
            pending_d = 1'b0;
        end
        if (ovr_clr) begin
            overrun_d = 8'd0;
        end

        if (wr && i_wb_sel[0] && reg_idx == RJ_MOTCTL) begin
            motctl_d = i_wb_dat[7:0];
        end
        if (wr && i_wb_sel[0] && reg_idx == RJ_IRQEN) begin
            irq_en_d = i_wb_dat[0];
        end

        bus_st_d = access ? ST_ACK : ST_IDLE;
        rdt_d    = access ? rd_word : 32'd0;
        irq_d    = pending_q & irq_en_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus_st_q  <= ST_IDLE;
            snap_q    <= '0;
            pending_q <= 1'b0;
            upd_cnt_q <= '0;
            overrun_q <= 8'd0;
            irq_en_q  <= 1'b0;
            motctl_q  <= 8'd0;
            rdt_q     <= 32'd0;
            irq_q     <= 1'b0;
        end else begin
            bus_st_q  <= bus_st_d;
            snap_q    <= snap_d;
            pending_q <= pending_d;
            upd_cnt_q <= upd_cnt_d;
            overrun_q <= overrun_d;
            irq_en_q  <= irq_en_d;
            motctl_q  <= motctl_d;
            rdt_q     <= rdt_d;
            irq_q     <= irq_d;
        end
    end

    assign o_wb_ack = (bus_st_q == ST_ACK);
    assign o_wb_rdt = rdt_q;
    assign o_motctl = motctl_q;
    assign o_irq    = irq_q;

endmodule

// File: tb/tb_rojo_update_capture.sv
// Directed bench for rojo_update_capture: cycle model of the register rules plus literal readback checks.
module tb_rojo_update_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd;
    logic [7:0]  locx, locy, sensors, botinfo;
    logic [7:0]  motctl;
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic        ack;
    logic [31:0] rdt;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rojo_update_capture #(.UPD_CNT_W(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_upd_sysregs (upd),
        .i_locx        (locx),
        .i_locy        (locy),
        .i_sensors     (sensors),
        .i_botinfo     (botinfo),
        .o_motctl      (motctl),
        .i_wb_adr      (adr),
        .i_wb_dat      (dat),
        .i_wb_sel      (sel),
        .i_wb_we       (we),
        .i_wb_cyc      (cyc),
        .i_wb_stb      (stb),
        .o_wb_ack      (ack),
        .o_wb_rdt      (rdt),
        .o_irq         (irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents as plain variables, updated once per rising clock.
    logic [31:0] m_snap;
    logic        m_pend, m_ien, m_ack, m_irq, m_armed, m_prev, m_valid;
    logic [15:0] m_cnt;
    logic [7:0]  m_ovr, m_mot;
    logic [31:0] m_rdt;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        logic        rise, acc, ackw, clro, pend_old;
        logic [31:0] rv;
        if (rst) begin
            m_snap = 0; m_pend = 0; m_ien = 0; m_ack = 0; m_irq = 0;
            m_cnt = 0; m_ovr = 0; m_mot = 0; m_rdt = 0;
            m_armed = 0; m_prev = 0; m_valid = 1;
        end else if (m_valid) begin
            rise = m_armed && upd && !m_prev;
            acc  = cyc && stb && !m_ack;
            case (adr[3:2])
                2'd0:    rv = m_snap;
                2'd1:    rv = {m_ovr, m_cnt, 7'd0, m_pend};
                2'd2:    rv = {24'd0, m_mot};
                default: rv = {31'd0, m_ien};
            endcase
            ackw = acc && we && adr[3:2] == 2'd1 && sel[0] && dat[0];
            clro = acc && we && adr[3:2] == 2'd1 && sel[0] && dat[1];
            pend_old = m_pend;
            m_irq = m_pend && m_ien;
            if (rise) begin
                if (pend_old && !ackw && m_ovr < 8'd255) m_ovr = m_ovr + 8'd1;
                m_snap = {locx, locy, sensors, botinfo};
                m_cnt  = m_cnt + 16'd1;
                m_pend = 1'b1;
            end else if (ackw) begin
                m_pend = 1'b0;
            end
            if (clro) m_ovr = 8'd0;
            if (acc && we && sel[0] && adr[3:2] == 2'd2) m_mot = dat[7:0];
            if (acc && we && sel[0] && adr[3:2] == 2'd3) m_ien = dat[0];
            m_ack   = acc;
            m_rdt   = acc ? rv : 32'd0;
            m_armed = 1'b1;
            m_prev  = upd;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ack", {31'd0, ack}, {31'd0, m_ack});
            chk("rdt", rdt, m_rdt);
            chk("motctl", {24'd0, motctl}, {24'd0, m_mot});
            chk("irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    task automatic bus(input logic [3:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic with_upd, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd  = 32'hDEAD_BEEF;
        @(negedge clk);
        adr = a; we = w; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        if (with_upd) upd = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                rd  = rdt;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; upd = 1'b0;
        chk("ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic rd_chk(input logic [3:0] a, input string nm, input logic [31:0] exp);
        logic [31:0] d;
        bus(a, 1'b0, 32'd0, 4'hF, 1'b0, d);
        chk(nm, d, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] unused_rd;
        bus(a, 1'b1, d, s, 1'b0, unused_rd);
    endtask

    task automatic pulse();
        @(negedge clk); upd = 1'b1;
        @(negedge clk); upd = 1'b0;
    endtask

    task automatic set_locs(input logic [31:0] v);
        {locx, locy, sensors, botinfo} = v;
    endtask

    initial begin
        logic [31:0] d;
        rst = 1'b1; upd = 1'b0; set_locs(32'd0);
        adr = 0; dat = 0; sel = 0; we = 0; cyc = 0; stb = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        rd_chk(4'h0, "rst_snap", 32'd0);
        rd_chk(4'h4, "rst_status", 32'd0);
        rd_chk(4'h8, "rst_motctl", 32'd0);
        rd_chk(4'hC, "rst_irqen", 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        set_locs(32'h12345678);
        pulse();
        rd_chk(4'h0, "snap_first", 32'h12345678);
        rd_chk(4'h4, "status_first", 32'h00000101);
        chk("irq_disabled", {31'd0, irq}, 32'd0);
        wr(4'hC, 32'd1, 4'b0001);
        repeat (2) @(negedge clk);
        chk("irq_enabled", {31'd0, irq}, 32'd1);
        wr(4'h4, 32'd1, 4'b0001);
        repeat (2) @(negedge clk);
        chk("irq_acked", {31'd0, irq}, 32'd0);
        rd_chk(4'h4, "status_acked", 32'h00000100);

        repeat (3) pulse();
        rd_chk(4'h4, "status_overrun2", 32'h02000401);
        wr(4'h4, 32'd2, 4'b0001);
        rd_chk(4'h4, "status_ovr_clr", 32'h00000401);

        @(negedge clk); upd = 1'b1;
        repeat (10) @(negedge clk);
        upd = 1'b0;
        rd_chk(4'h4, "status_held", 32'h01000501);

        wr(4'h4, 32'd3, 4'b0001);
        rd_chk(4'h4, "status_clr_both", 32'h00000500);
        pulse();
        rd_chk(4'h4, "status_pre_sim", 32'h00000601);
        set_locs(32'hAABBCCDD);
        bus(4'h4, 1'b1, 32'd1, 4'b0001, 1'b1, d);
        rd_chk(4'h4, "status_ack_vs_upd", 32'h00000701);
        rd_chk(4'h0, "snap_ack_vs_upd", 32'hAABBCCDD);

        set_locs(32'h11223344);
        bus(4'h0, 1'b0, 32'd0, 4'hF, 1'b1, d);
        chk("snap_read_on_rise", d, 32'hAABBCCDD);
        rd_chk(4'h0, "snap_after_rise", 32'h11223344);

        wr(4'h8, 32'h000000A5, 4'b0001);
        @(negedge clk);
        chk("motctl_a5", {24'd0, motctl}, 32'h000000A5);
        wr(4'h8, 32'h000000FF, 4'b0010);
        @(negedge clk);
        chk("motctl_sel", {24'd0, motctl}, 32'h000000A5);
        rd_chk(4'h8, "motctl_rd", 32'h000000A5);

        repeat (260) pulse();
        rd_chk(4'h4, "status_saturate", 32'hFF010C01);

        @(negedge clk); upd = 1'b1; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rd_chk(4'h4, "status_upd_at_reset", 32'd0);
        rd_chk(4'h0, "snap_upd_at_reset", 32'd0);
        upd = 1'b0;

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1);
    end

endmodule
